multiplier_control_unit: RTL
============================

// Module: multiplier_control_unit
// PURPOSE
//  Sequencer for the signed add-shift multiplier datapath: register units A/B,
//  the X sign-extension unit and the adder/subtractor.
//  Issues load/clear/shift/add-subtract strobes for WIDTH iterations per Run,
//  then holds a Done state.
//  Sits between the board switch/button synchronisers and the datapath.
//  Holds no product bits itself.
// PARAMETERS
//  WIDTH   8   operand width; number of add/shift iterations per run (>=2)
// PORTS
//  Clk           in   1              system clock, rising edge
//  Reset_n       in   1              asynchronous active-low reset
//  Run           in   1              start request, level; synchronised upstream
//  ClearA_LoadB  in   1              idle-time request: load B from switches, clear A and X
//  M             in   1              LSB of register B (current multiplier bit)
//  Clr_A         out  1              synchronous clear of register A and X
//  Ld_B          out  1              load register B from switch data
//  Ld_A          out  1              load register A with adder result
//  Ld_X          out  1              load X with the adder sign bit
//  Fn            out  1              adder function: 0 = A+S, 1 = A-S
//  Shift_En      out  1              shift X->A->B right by one
//  Busy          out  1              high from CLR through the last SHIFT
//  Done          out  1              high in DONE state
//  Iter          out  $clog2(WIDTH)  current iteration index
// BEHAVIOUR
//  - One clock domain. Reset_n low forces asynchronously:
//    state=IDLE, Iter=0, and every output 0, including the IDLE decodes.
//  - States: IDLE, CLR, ADD, SHIFT, DONE. State and Iter are the only flops.
//    All outputs decode combinationally from state, Iter, Run, ClearA_LoadB and M.
//  - IDLE:
//    - Run=1 -> CLR; Run has priority over ClearA_LoadB.
//    - Run=0, ClearA_LoadB=1 -> Ld_B=1, Clr_A=1 each cycle it is held; stay IDLE.
//    - Otherwise all strobes 0.
//  - CLR:
//    - Clr_A=1 (A and X zeroed; B untouched); Iter<=0; -> ADD.
//  - ADD:
//    - Ld_A=Ld_X=M.
//    - Fn=1 only when Iter==WIDTH-1 (two's-complement sign bit subtracts), else 0.
//    - Fn is driven 0 whenever Ld_A=0.
//    - -> SHIFT.
//  - SHIFT:
//    - Shift_En=1.
//    - If Iter==WIDTH-1 -> DONE.
//    - Else Iter<=Iter+1 and -> ADD.
//  - DONE:
//    - No strobes; Done=1.
//    - Stay while Run=1. Run=0 -> IDLE, so one press gives exactly one run.
//    - Iter holds WIDTH-1 in DONE.
//  - Latency, counted from the first IDLE cycle with Run=1:
//    - CLR at +1.
//    - 2*WIDTH cycles of ADD/SHIFT.
//    - Done first high at +2*WIDTH+2 (+18 for WIDTH=8).
//  - Exactly WIDTH Shift_En pulses per run.
//  - Ld_A pulse count equals the number of 1 bits of the original B.
//  - Strobes are mutually exclusive except Ld_A/Ld_X (paired) and Clr_A/Ld_B (paired).
//  - Run and ClearA_LoadB are ignored outside IDLE and DONE.
//  - Run dropping mid-operation does not abort the run.
//  - Reset_n low at any point aborts immediately with all strobes 0.
//    The datapath is left as-is.
//  - Iter wraps only via CLR; it never counts past WIDTH-1.
// TESTING
//  1. Reset: Reset_n low mid-ADD with M=1 -> Ld_A/Ld_X drop in the same cycle,
//     state IDLE, Iter=0, Done=0.
//  2. Run=0, ClearA_LoadB=1 for 3 cycles in IDLE -> Ld_B=Clr_A=1 for exactly 3 cycles;
//     Busy=0.
//  3. B=8'b1000_0001, one Run press:
//     - Ld_A on Iter 0 with Fn=0, and on Iter 7 with Fn=1; no other Ld_A.
//     - 8 Shift_En pulses; Done at cycle +18.
//  4. B=8'h00 -> zero Ld_A/Ld_X pulses, still 8 Shift_En, Done at +18.
//  5. Run held high for 40 cycles -> exactly one run; Done stays 1.
//     After Run 0->1 again -> second run starts with a CLR pulse.
//  6. Run=1 and ClearA_LoadB=1 together in IDLE -> Ld_B never asserted;
//     CLR follows next cycle.

Source files
------------

// File: rtl/multiplier_control_unit.sv
// Sequencer for the signed add-shift multiplier: drives clear/load/add/shift strobes to the A/B/X datapath.
// Latency: CLR one cycle after Run is seen in IDLE, WIDTH ADD/SHIFT pairs follow, Done at +2*WIDTH+2.
// Backpressure: none; Run/ClearA_LoadB are sampled only in IDLE/DONE and a started run always completes.
module multiplier_control_unit #(
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Run,
  input  logic                     ClearA_LoadB,
  input  logic                     M,
  output logic                     Clr_A,
  output logic                     Ld_B,
  output logic                     Ld_A,
  output logic                     Ld_X,
  output logic                     Fn,
  output logic                     Shift_En,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(WIDTH)-1:0] Iter
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] iter_q, iter_nxt;

  // Decoded strobes before reset gating.
  logic clr_a_c, ld_b_c, ld_a_c, ld_x_c, fn_c, shift_en_c, busy_c, done_c;

  // State and iteration counter; the only storage in the block.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      iter_q <= iter_nxt;
    end
  end

  // Next-state logic and combinational strobe decode.
  always_comb begin
    state_nxt  = state;
    iter_nxt   = iter_q;
    clr_a_c    = 1'b0;
    ld_b_c     = 1'b0;
    ld_a_c     = 1'b0;
    ld_x_c     = 1'b0;
    fn_c       = 1'b0;
    shift_en_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        // Run wins over the idle-time load request.
        if (Run) begin
          state_nxt = S_CLR;
        end else if (ClearA_LoadB) begin
          ld_b_c  = 1'b1;
          clr_a_c = 1'b1;
        end
      end
      S_CLR: begin
        clr_a_c   = 1'b1;
        busy_c    = 1'b1;
        iter_nxt  = '0;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        busy_c    = 1'b1;
        ld_a_c    = M;
        ld_x_c    = M;
        // Last multiplier bit carries negative weight, so subtract there.
        fn_c      = M && (iter_q == LAST);
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy_c     = 1'b1;
        shift_en_c = 1'b1;
        if (iter_q == LAST) begin
          state_nxt = S_DONE;
        end else begin
          iter_nxt  = iter_q + IW'(1);
          state_nxt = S_ADD;
        end
      end
      S_DONE: begin
        done_c = 1'b1;
        // Wait for Run release so one press yields exactly one run.
        if (!Run) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        iter_nxt  = '0;
      end
    endcase
  end

  // Reset forces every output low, including IDLE decodes driven by inputs.
  assign Clr_A    = Reset_n & clr_a_c;
  assign Ld_B     = Reset_n & ld_b_c;
  assign Ld_A     = Reset_n & ld_a_c;
  assign Ld_X     = Reset_n & ld_x_c;
  assign Fn       = Reset_n & fn_c;
  assign Shift_En = Reset_n & shift_en_c;
  assign Busy     = Reset_n & busy_c;
  assign Done     = Reset_n & done_c;
  assign Iter     = iter_q;

endmodule
